// File: rtl/mw_power_sequencer.sv
// Microwave control unit: keypad entry of a BCD MM:SS time, power level select,
// 1 Hz countdown and power-proportional magnetron duty cycle over a 10 s window.
module mw_power_sequencer #(
    parameter int DEFAULT_POWER = 10,
    parameter int DONE_SECS     = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       power_key,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] power_level
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SET_POWER = 3'd1,
        S_COOK      = 3'd2,
        S_PAUSE     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [3:0] PWR_DEF = 4'(DEFAULT_POWER);
    localparam logic [7:0] DONE_LAST = 8'(DONE_SECS - 1);

    state_t     state_q, state_d;
    logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
    logic [3:0] power_q, power_d, phase_q, phase_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic [3:0] mt_dec, mo_dec, st_dec, so_dec;
    logic       time_zero, dec_zero, key_ok;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
            power_q <= PWR_DEF;
            phase_q <= 4'd0;
            dcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
            power_q <= power_d;
            phase_q <= phase_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // BCD borrow chain; seconds tens reloads 5 only on a borrow so entries like 0099 count as typed.
    always_comb begin
        mt_dec = mt_q;
        mo_dec = mo_q;
        st_dec = st_q;
        so_dec = so_q;
        if (so_q != 4'd0) begin
            so_dec = so_q - 4'd1;
        end else begin
            so_dec = 4'd9;
            if (st_q != 4'd0) begin
                st_dec = st_q - 4'd1;
            end else begin
                st_dec = 4'd5;
                if (mo_q != 4'd0) begin
                    mo_dec = mo_q - 4'd1;
                end else begin
                    mo_dec = 4'd9;
                    mt_dec = mt_q - 4'd1;
                end
            end
        end
    end

    assign time_zero = ({mt_q, mo_q, st_q, so_q} == 16'd0);
    assign dec_zero  = ({mt_dec, mo_dec, st_dec, so_dec} == 16'd0);
    assign key_ok    = key_valid && (key_digit <= 4'd9);

    // Priority within a cycle: stop > start > power_key > key_valid.
    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        power_d = power_q;
        phase_d = phase_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_IDLE: begin
                if (stop) begin
                    {mt_d, mo_d, st_d, so_d} = 16'd0;
                    power_d = PWR_DEF;
                end else if (start) begin
                    if (!time_zero && door_closed) begin
                        state_d = S_COOK;
                        phase_d = 4'd0;
                    end
                end else if (power_key) begin
                    state_d = S_SET_POWER;
                end else if (key_ok) begin
                    {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, key_digit};
                end
            end
            S_SET_POWER: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (key_ok && !start && !power_key) begin
                    power_d = (key_digit == 4'd0) ? 4'd10 : key_digit;
                    state_d = S_IDLE;
                end
            end
            S_COOK: begin
                if (stop || !door_closed) begin
                    state_d = S_PAUSE;
                end else if (tick_1hz) begin
                    {mt_d, mo_d, st_d, so_d} = {mt_dec, mo_dec, st_dec, so_dec};
                    phase_d = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
                    if (dec_zero) begin
                        state_d = S_DONE;
                        dcnt_d  = 8'd0;
                    end
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    {mt_d, mo_d, st_d, so_d} = 16'd0;
                    power_d = PWR_DEF;
                end else if (start && door_closed) begin
                    state_d = S_COOK;
                end
            end
            S_DONE: begin
                if (start || stop || key_valid) begin
                    state_d = S_IDLE;
                    dcnt_d  = 8'd0;
                end else if (tick_1hz) begin
                    if (dcnt_q == DONE_LAST) begin
                        state_d = S_IDLE;
                        dcnt_d  = 8'd0;
                    end else begin
                        dcnt_d = dcnt_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mag_on      = (state_q == S_COOK) && door_closed && (phase_q < power_q);
        done        = (state_q == S_DONE);
        state       = state_q;
        min_tens    = mt_q;
        min_ones    = mo_q;
        sec_tens    = st_q;
        sec_ones    = so_q;
        power_level = power_q;
    end

endmodule

// File: tb/tb_mw_power_sequencer.sv
// Bench for mw_power_sequencer: directed scenarios plus a random run against a
// model that keeps the time as minutes/seconds integers.
module tb_mw_power_sequencer;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       tick_1hz = 1'b0, key_valid = 1'b0, power_key = 1'b0;
    logic       start = 1'b0, stop = 1'b0, door_closed = 1'b1;
    logic [3:0] key_digit = 4'd0;
    logic       mag_on, done;
    logic [2:0] state;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, power_level;

    int errors = 0;
    int checks = 0;

    // Reference model (state codes as given: 0 idle,1 set power,2 cook,3 pause,4 done)
    int m_st, m_mins, m_secs, m_power, m_phase, m_dcnt;

    mw_power_sequencer #(.DEFAULT_POWER(10), .DONE_SECS(3)) dut (
        .clk(clk), .clear(clear), .tick_1hz(tick_1hz), .key_valid(key_valid),
        .key_digit(key_digit), .power_key(power_key), .start(start), .stop(stop),
        .door_closed(door_closed), .mag_on(mag_on), .done(done), .state(state),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .power_level(power_level)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_mins = 0; m_secs = 0; m_power = 10; m_phase = 0; m_dcnt = 0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kd, input logic pk,
                              input logic st, input logic sp, input logic tk, input logic door);
        int val;
        case (m_st)
            0: begin
                if (sp) begin m_mins = 0; m_secs = 0; m_power = 10; end
                else if (st) begin
                    if ((m_mins + m_secs) > 0 && door) begin m_st = 2; m_phase = 0; end
                end
                else if (pk) m_st = 1;
                else if (kv && kd <= 9) begin
                    val = ((m_mins * 100 + m_secs) * 10 + int'(kd)) % 10000;
                    m_mins = val / 100;
                    m_secs = val % 100;
                end
            end
            1: begin
                if (sp) m_st = 0;
                else if (!st && !pk && kv && kd <= 9) begin
                    m_power = (kd == 0) ? 10 : int'(kd);
                    m_st = 0;
                end
            end
            2: begin
                if (sp || !door) m_st = 3;
                else if (tk) begin
                    if (m_secs > 0) m_secs--;
                    else begin m_secs = 59; m_mins--; end
                    m_phase = (m_phase + 1) % 10;
                    if (m_mins == 0 && m_secs == 0) begin m_st = 4; m_dcnt = 0; end
                end
            end
            3: begin
                if (sp) begin m_st = 0; m_mins = 0; m_secs = 0; m_power = 10; end
                else if (st && door) m_st = 2;
            end
            default: begin
                if (st || sp || kv) begin m_st = 0; m_dcnt = 0; end
                else if (tk) begin
                    m_dcnt++;
                    if (m_dcnt == 3) begin m_st = 0; m_dcnt = 0; end
                end
            end
        endcase
    endtask

    // Called at a negedge; applies one cycle of pulses and returns at the next negedge.
    task automatic pulse(input logic kv, input logic [3:0] kd, input logic pk,
                         input logic st, input logic sp, input logic tk);
        key_valid = kv; key_digit = kd; power_key = pk; start = st; stop = sp; tick_1hz = tk;
        @(posedge clk);
        model_step(kv, kd, pk, st, sp, tk, door_closed);
        @(negedge clk);
        key_valid = 1'b0; power_key = 1'b0; start = 1'b0; stop = 1'b0; tick_1hz = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);  pulse(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic press_start();             pulse(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
    task automatic press_stop();              pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
    task automatic press_power();             pulse(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        clear = 1'b1;
        door_closed = 1'b1;
        model_reset();
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        #1;
        checks++;
        if ({state, mag_on, done} !== 5'b0 || {min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000
            || power_level !== 4'd10) begin
            $display("FAIL reset: state=%0d mag=%b done=%b digits=%h power=%0d, need 0 0 0 0000 10",
                     state, mag_on, done, {min_tens, min_ones, sec_tens, sec_ones}, power_level);
            errors++;
        end
        do_reset();
    endtask

    task automatic test_cook_to_done();
        do_reset();
        key(4'd1); key(4'd3); key(4'd0);
        press_start();
        checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0130 || state !== 3'd2 || mag_on !== 1'b1) begin
            $display("FAIL cook_start: digits=%h state=%0d mag=%b, need 0130 2 1",
                     {min_tens, min_ones, sec_tens, sec_ones}, state, mag_on);
            errors++;
        end
        tick(31);
        checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0059) begin
            $display("FAIL cook_borrow: digits=%h, need 0059", {min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        tick(58);
        checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0001 || state !== 3'd2 || done !== 1'b0) begin
            $display("FAIL cook_last_sec: digits=%h state=%0d done=%b, need 0001 2 0",
                     {min_tens, min_ones, sec_tens, sec_ones}, state, done);
            errors++;
        end
        tick(1);
        checks++;
        if (state !== 3'd4 || done !== 1'b1 || mag_on !== 1'b0 || {min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000) begin
            $display("FAIL done_entry: state=%0d done=%b mag=%b digits=%h, need 4 1 0 0000",
                     state, done, mag_on, {min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        tick(2);
        checks++;
        if (state !== 3'd4 || done !== 1'b1) begin
            $display("FAIL done_hold: state=%0d done=%b, need 4 1", state, done);
            errors++;
        end
        tick(1);
        checks++;
        if (state !== 3'd0 || done !== 1'b0) begin
            $display("FAIL done_exit: state=%0d done=%b, need 0 0", state, done);
            errors++;
        end
    endtask

    task automatic test_power_duty();
        do_reset();
        press_power();
        checks++;
        if (state !== 3'd1) begin
            $display("FAIL set_power_enter: state=%0d, need 1", state);
            errors++;
        end
        key(4'd3);
        checks++;
        if (state !== 3'd0 || power_level !== 4'd3) begin
            $display("FAIL set_power: state=%0d power=%0d, need 0 3", state, power_level);
            errors++;
        end
        key(4'd1); key(4'd0);
        press_start();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (mag_on !== (i < 3)) begin
                $display("FAIL duty phase %0d: mag=%b, need %b", i, mag_on, (i < 3));
                errors++;
            end
            checks++;
            if (state !== 3'd2) begin
                $display("FAIL duty state phase %0d: state=%0d, need 2", i, state);
                errors++;
            end
            tick(1);
        end
        checks++;
        if (state !== 3'd4 || done !== 1'b1) begin
            $display("FAIL ten_tick_done: state=%0d done=%b, need 4 1", state, done);
            errors++;
        end
        key(4'd7);
        checks++;
        if (state !== 3'd0 || {min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000 || power_level !== 4'd3) begin
            $display("FAIL done_key_consumed: state=%0d digits=%h power=%0d, need 0 0000 3",
                     state, {min_tens, min_ones, sec_tens, sec_ones}, power_level);
            errors++;
        end
        press_power(); key(4'd0);
        checks++;
        if (power_level !== 4'd10) begin
            $display("FAIL power_zero_is_10: power=%0d, need 10", power_level);
            errors++;
        end
    endtask

    task automatic test_door_pause();
        do_reset();
        key(4'd2); key(4'd0);
        press_start();
        tick(5);
        door_closed = 1'b0;
        tick_1hz = 1'b1;
        #1;
        checks++;
        if (mag_on !== 1'b0 || state !== 3'd2) begin
            $display("FAIL door_open_comb: mag=%b state=%0d, need 0 2", mag_on, state);
            errors++;
        end
        tick_1hz = 1'b0;
        pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (state !== 3'd3 || {min_tens, min_ones, sec_tens, sec_ones} !== 16'h0015) begin
            $display("FAIL door_pause: state=%0d digits=%h, need 3 0015",
                     state, {min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        press_start();
        checks++;
        if (state !== 3'd3 || {min_tens, min_ones, sec_tens, sec_ones} !== 16'h0015) begin
            $display("FAIL start_door_open: state=%0d digits=%h, need 3 0015",
                     state, {min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        door_closed = 1'b1;
        press_start();
        tick(1);
        checks++;
        if (state !== 3'd2 || {min_tens, min_ones, sec_tens, sec_ones} !== 16'h0014 || mag_on !== 1'b1) begin
            $display("FAIL resume: state=%0d digits=%h mag=%b, need 2 0014 1",
                     state, {min_tens, min_ones, sec_tens, sec_ones}, mag_on);
            errors++;
        end
    endtask

    task automatic test_stop();
        do_reset();
        press_power(); key(4'd4);
        key(4'd5);
        press_start();
        tick(1);
        pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (state !== 3'd3 || {min_tens, min_ones, sec_tens, sec_ones} !== 16'h0004) begin
            $display("FAIL stop_pause: state=%0d digits=%h, need 3 0004",
                     state, {min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        press_stop();
        checks++;
        if (state !== 3'd0 || {min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000 || power_level !== 4'd10) begin
            $display("FAIL stop_idle: state=%0d digits=%h power=%0d, need 0 0000 10",
                     state, {min_tens, min_ones, sec_tens, sec_ones}, power_level);
            errors++;
        end
    endtask

    task automatic test_entry();
        do_reset();
        press_start();
        checks++;
        if (state !== 3'd0) begin
            $display("FAIL start_zero: state=%0d, need 0", state);
            errors++;
        end
        for (int d = 1; d <= 5; d++) key(4'(d));
        checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h2345) begin
            $display("FAIL shift: digits=%h, need 2345", {min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        key(4'd12);
        checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h2345) begin
            $display("FAIL bad_digit: digits=%h, need 2345", {min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        door_closed = 1'b0;
        press_start();
        checks++;
        if (state !== 3'd0) begin
            $display("FAIL start_door_open_idle: state=%0d, need 0", state);
            errors++;
        end
        door_closed = 1'b1;
    endtask

    task automatic test_async_clear();
        do_reset();
        key(4'd9);
        press_start();
        tick(2);
        checks++;
        if (mag_on !== 1'b1 || state !== 3'd2) begin
            $display("FAIL pre_clear: mag=%b state=%0d, need 1 2", mag_on, state);
            errors++;
        end
        #2 clear = 1'b1;
        #1;
        checks++;
        if (mag_on !== 1'b0 || state !== 3'd0 || {min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000
            || power_level !== 4'd10) begin
            $display("FAIL async_clear: mag=%b state=%0d digits=%h power=%0d, need 0 0 0000 10",
                     mag_on, state, {min_tens, min_ones, sec_tens, sec_ones}, power_level);
            errors++;
        end
        model_reset();
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] kd;
        logic [2:0] e_state;
        logic [15:0] e_dig;
        logic e_mag, e_done;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 19) == 0) door_closed = ~door_closed;
            kd = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            pulse($urandom_range(0, 7) == 0, kd, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 14) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0);
            e_state = 3'(m_st);
            e_dig   = {4'(m_mins / 10), 4'(m_mins % 10), 4'(m_secs / 10), 4'(m_secs % 10)};
            e_mag   = (m_st == 2) && door_closed && (m_phase < m_power);
            e_done  = (m_st == 4);
            checks++;
            if ({state, mag_on, done, min_tens, min_ones, sec_tens, sec_ones, power_level}
                !== {e_state, e_mag, e_done, e_dig, 4'(m_power)}) begin
                $display("FAIL random cycle %0d: state=%0d mag=%b done=%b digits=%h power=%0d, need %0d %b %b %h %0d",
                         n, state, mag_on, done, {min_tens, min_ones, sec_tens, sec_ones}, power_level,
                         e_state, e_mag, e_done, e_dig, m_power);
                errors++;
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_cook_to_done();
        test_power_duty();
        test_door_pause();
        test_stop();
        test_entry();
        test_async_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
